// File: rtl/ppg_pkg.sv
// rtl/ppg_pkg.sv - shared widths, phase and FSM encodings for the PPG phase filter
package ppg_pkg;

  localparam int ADC_W = 8;
  localparam int OUT_W = 20;
  localparam int CNT_W = 4;

  // Encoding matches {LED_RED, LED_IR} so decode is a plain cast
  typedef enum logic [1:0] {
    PH_NONE = 2'b00,
    PH_IR   = 2'b01,
    PH_RED  = 2'b10,
    PH_BAD  = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_HOLD
  } state_t;

  function automatic phase_t decode_phase(input logic red, input logic ir);
    return phase_t'({red, ir});
  endfunction

  function automatic logic is_lit(input phase_t ph);
    return (ph == PH_RED) || (ph == PH_IR);
  endfunction

endpackage

// File: rtl/ppg_boxcar.sv
// rtl/ppg_boxcar.sv - per-channel moving-sum filter over the last 2^TAPS_LOG2 phase means
module ppg_boxcar
  import ppg_pkg::*;
#(
  parameter int TAPS_LOG2 = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [ADC_W-1:0] din,
  output logic [OUT_W-1:0] sum,
  output logic             valid
);

  localparam int TAPS = 1 << TAPS_LOG2;

  logic [ADC_W-1:0]     taps [TAPS];
  logic [TAPS_LOG2-1:0] ptr;
  logic [OUT_W-1:0]     sum_next;

  // New sum adds the incoming mean and retires the oldest tap; never goes negative
  always_comb begin
    sum_next = sum + OUT_W'(din) - OUT_W'(taps[ptr]);
  end

  // Ring buffer, running sum and one-cycle valid pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < TAPS; i++) begin
        taps[i] <= '0;
      end
      ptr   <= '0;
      sum   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= push;
      if (push) begin
        taps[ptr] <= din;
        ptr       <= ptr + 1'b1;
        sum       <= sum_next;
      end
    end
  end

endmodule

// File: rtl/ppg_phase_filter.sv
// rtl/ppg_phase_filter.sv - per-LED-phase settle/average front end feeding RED and IR boxcars
module ppg_phase_filter
  import ppg_pkg::*;
#(
  parameter int SETTLE    = 2,
  parameter int ACC_LOG2  = 2,
  parameter int TAPS_LOG2 = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Enable,
  input  logic [ADC_W-1:0] ADC,
  input  logic             LED_RED,
  input  logic             LED_IR,
  output logic [OUT_W-1:0] Out_RED_Filtered,
  output logic [OUT_W-1:0] Out_IR_Filtered,
  output logic             RED_Valid,
  output logic             IR_Valid,
  output logic             Phase_Error
);

  localparam int ACC_N = 1 << ACC_LOG2;
  localparam int ACC_W = ADC_W + ACC_LOG2;

  phase_t           ph;
  phase_t           ph_q;
  phase_t           ph_q_nx;
  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nx;
  logic [ADC_W-1:0] mean;
  logic             phase_edge;
  logic             push_red;
  logic             push_ir;
  logic             err_nx;

  assign ph         = decode_phase(LED_RED, LED_IR);
  assign phase_edge = (state != ST_IDLE) && (ph != ph_q);
  assign mean       = acc[ACC_W-1:ACC_LOG2];

  // Next-state, counters, accumulator and push steering
  always_comb begin
    state_nx = state;
    ph_q_nx  = ph_q;
    cnt_nx   = cnt;
    acc_nx   = acc;
    push_red = 1'b0;
    push_ir  = 1'b0;
    err_nx   = (ph == PH_BAD);

    if (!Enable) begin
      // Leaving OPERATION abandons whatever phase was in progress
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      acc_nx   = '0;
    end else if (phase_edge) begin
      if (state == ST_HOLD) begin
        push_red = (ph_q == PH_RED);
        push_ir  = (ph_q == PH_IR);
      end else begin
        err_nx = 1'b1;
      end
      acc_nx = '0;
      // The edge sample itself is settle #0 of the new phase
      if (is_lit(ph)) begin
        state_nx = ST_SETTLE;
        ph_q_nx  = ph;
        cnt_nx   = CNT_W'(1);
      end else begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_lit(ph)) begin
            state_nx = ST_SETTLE;
            ph_q_nx  = ph;
            cnt_nx   = CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt == CNT_W'(SETTLE)) begin
            state_nx = ST_ACCUM;
            acc_nx   = ACC_W'(ADC);
            cnt_nx   = CNT_W'(1);
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        ST_ACCUM: begin
          acc_nx = acc + ACC_W'(ADC);
          if (cnt == CNT_W'(ACC_N - 1)) begin
            state_nx = ST_HOLD;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          // ST_HOLD: mean is frozen until the phase changes
        end
      endcase
    end
  end

  // State, phase latch, counters and registered error pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      ph_q        <= PH_NONE;
      cnt         <= '0;
      acc         <= '0;
      Phase_Error <= 1'b0;
    end else begin
      state       <= state_nx;
      ph_q        <= ph_q_nx;
      cnt         <= cnt_nx;
      acc         <= acc_nx;
      Phase_Error <= err_nx;
    end
  end

  ppg_boxcar #(.TAPS_LOG2(TAPS_LOG2)) u_red (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push_red),
    .din   (mean),
    .sum   (Out_RED_Filtered),
    .valid (RED_Valid)
  );

  ppg_boxcar #(.TAPS_LOG2(TAPS_LOG2)) u_ir (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push_ir),
    .din   (mean),
    .sum   (Out_IR_Filtered),
    .valid (IR_Valid)
  );

endmodule

// File: tb/tb_ppg_phase_filter.sv
// tb/tb_ppg_phase_filter.sv - randomized and directed bench for ppg_phase_filter against a run-length model
module tb_ppg_phase_filter;

  localparam int SETTLE = 2;
  localparam int ACC_N  = 4;
  localparam int TAPS   = 16;
  localparam int P_NONE = 0;
  localparam int P_IR   = 1;
  localparam int P_RED  = 2;
  localparam int P_BAD  = 3;

  logic        CLK;
  logic        RST;
  logic        Enable;
  logic [7:0]  ADC;
  logic        LED_RED;
  logic        LED_IR;
  logic [19:0] Out_RED_Filtered;
  logic [19:0] Out_IR_Filtered;
  logic        RED_Valid;
  logic        IR_Valid;
  logic        Phase_Error;

  int n_checks;
  int n_fail;

  // Model: a "run" is a stretch of one lit phase while the filter is tracking it
  int m_active;
  int m_ph;
  int m_len;
  int m_acc;
  int hist_red[$];
  int hist_ir[$];
  logic [31:0] e_red;
  logic [31:0] e_ir;
  logic [31:0] e_rv;
  logic [31:0] e_iv;
  logic [31:0] e_err;

  ppg_phase_filter dut (
    .CLK              (CLK),
    .RST              (RST),
    .Enable           (Enable),
    .ADC              (ADC),
    .LED_RED          (LED_RED),
    .LED_IR           (LED_IR),
    .Out_RED_Filtered (Out_RED_Filtered),
    .Out_IR_Filtered  (Out_IR_Filtered),
    .RED_Valid        (RED_Valid),
    .IR_Valid         (IR_Valid),
    .Phase_Error      (Phase_Error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("out_red", {12'd0, Out_RED_Filtered}, e_red);
    chk("out_ir", {12'd0, Out_IR_Filtered}, e_ir);
    chk("red_valid", {31'd0, RED_Valid}, e_rv);
    chk("ir_valid", {31'd0, IR_Valid}, e_iv);
    chk("phase_error", {31'd0, Phase_Error}, e_err);
  endtask

  task automatic model_reset();
    hist_red.delete();
    hist_ir.delete();
    for (int i = 0; i < TAPS; i++) begin
      hist_red.push_back(0);
      hist_ir.push_back(0);
    end
    m_active = 0;
    m_ph     = P_NONE;
    m_len    = 0;
    m_acc    = 0;
    e_red    = 0;
    e_ir     = 0;
    e_rv     = 0;
    e_iv     = 0;
    e_err    = 0;
  endtask

  task automatic model_push(input int ch, input int mean);
    int s;
    s = 0;
    if (ch == P_RED) begin
      hist_red.push_back(mean);
      void'(hist_red.pop_front());
      foreach (hist_red[k]) s += hist_red[k];
      e_red = s;
      e_rv  = 1;
    end else begin
      hist_ir.push_back(mean);
      void'(hist_ir.pop_front());
      foreach (hist_ir[k]) s += hist_ir[k];
      e_ir = s;
      e_iv = 1;
    end
  endtask

  task automatic model_start(input int p);
    m_active = 1;
    m_ph     = p;
    m_len    = 1;
    m_acc    = 0;
  endtask

  task automatic model_update(input int en, input int p, input int a);
    e_rv  = 0;
    e_iv  = 0;
    e_err = (p == P_BAD);
    if (m_active != 0) begin
      if (en == 0) begin
        m_active = 0;
      end else if (p != m_ph) begin
        if (m_len >= SETTLE + ACC_N) model_push(m_ph, m_acc / ACC_N);
        else e_err = 1;
        m_active = 0;
        if (p == P_RED || p == P_IR) model_start(p);
      end else begin
        if (m_len >= SETTLE && m_len < SETTLE + ACC_N) m_acc += a;
        m_len++;
      end
    end else if (en != 0 && (p == P_RED || p == P_IR)) begin
      model_start(p);
    end
  endtask

  task automatic step(input int en, input int p, input int a);
    logic [1:0] pv;
    logic [7:0] av;
    pv      = p[1:0];
    av      = a[7:0];
    Enable  = (en != 0);
    LED_RED = pv[1];
    LED_IR  = pv[0];
    ADC     = av;
    @(posedge CLK);
    model_update(en, p, int'(av));
    #1 check_all();
  endtask

  // mode 0: constant base, 1: ramp from 0, 2: random
  task automatic run_phase(input int p, input int len, input int mode, input int base);
    for (int i = 0; i < len; i++) begin
      if (mode == 0) step(1, p, base);
      else if (mode == 1) step(1, p, i);
      else step(1, p, int'($urandom_range(0, 255)));
    end
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_reset();
      #1 check_all();
    end
    RST = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    Enable   = 1'b0;
    ADC      = 8'd0;
    LED_RED  = 1'b0;
    LED_IR   = 1'b0;
    model_reset();
    do_reset(3);
    step(0, P_NONE, 0);

    // Steady alternating phases, constant levels
    run_phase(P_RED, 10, 0, 100);
    step(1, P_IR, 200);
    chk("first_red_out", {12'd0, Out_RED_Filtered}, 32'd100);
    chk("first_red_valid", {31'd0, RED_Valid}, 32'd1);
    run_phase(P_IR, 9, 0, 200);
    for (int n = 0; n < 17; n++) begin
      run_phase(P_RED, 10, 0, 100);
      run_phase(P_IR, 10, 0, 200);
    end
    chk("red_steady", {12'd0, Out_RED_Filtered}, 32'd1600);
    chk("ir_steady", {12'd0, Out_IR_Filtered}, 32'd3200);

    // Ramp inside RED: mean of samples 2..5 is 3
    run_phase(P_RED, 10, 1, 0);
    step(1, P_IR, 7);
    chk("ramp_first_push", {12'd0, Out_RED_Filtered}, 32'd1503);
    run_phase(P_IR, 9, 2, 0);
    for (int n = 0; n < 3; n++) begin
      run_phase(P_RED, 10, 1, 0);
      run_phase(P_IR, 10, 2, 0);
    end

    // Phase cut short during accumulation
    run_phase(P_RED, 4, 2, 0);
    step(1, P_IR, 9);
    chk("cut_error", {31'd0, Phase_Error}, 32'd1);
    chk("cut_no_valid", {31'd0, RED_Valid}, 32'd0);
    run_phase(P_IR, 9, 2, 0);

    // Both LEDs on for one cycle mid-phase, then recovery
    run_phase(P_RED, 6, 2, 0);
    step(1, P_BAD, 33);
    chk("bad_error", {31'd0, Phase_Error}, 32'd1);
    run_phase(P_RED, 3, 2, 0);
    run_phase(P_IR, 10, 2, 0);
    run_phase(P_RED, 10, 2, 0);
    run_phase(P_IR, 10, 2, 0);

    // Enable dropped during accumulation
    run_phase(P_RED, 5, 2, 0);
    for (int i = 0; i < 3; i++) step(0, P_RED, int'($urandom_range(0, 255)));
    run_phase(P_RED, 2, 2, 0);
    run_phase(P_IR, 10, 2, 0);
    run_phase(P_RED, 10, 2, 0);
    run_phase(P_IR, 10, 2, 0);

    // Random phases, lengths, dark gaps and enable drops
    for (int n = 0; n < 60; n++) begin
      int p;
      int len;
      p   = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 14));
      for (int i = 0; i < len; i++) begin
        step(($urandom_range(0, 15) != 0) ? 1 : 0, p, int'($urandom_range(0, 255)));
      end
    end

    // Reset while holding a full RED history
    for (int n = 0; n < 17; n++) begin
      run_phase(P_RED, 10, 0, 100);
      run_phase(P_IR, 10, 0, 200);
    end
    run_phase(P_RED, 8, 0, 100);
    chk("pre_reset_red", {12'd0, Out_RED_Filtered}, 32'd1600);
    do_reset(1);
    chk("post_reset_red", {12'd0, Out_RED_Filtered}, 32'd0);
    chk("post_reset_valid", {31'd0, RED_Valid}, 32'd0);
    step(1, P_NONE, 0);
    run_phase(P_RED, 10, 0, 50);
    step(1, P_IR, 0);
    chk("post_reset_first_push", {12'd0, Out_RED_Filtered}, 32'd50);
    run_phase(P_IR, 9, 2, 0);
    step(0, P_NONE, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
